q_measure_frontend: RTL and testbench
=====================================

Name: q_measure_frontend

Overview:
- Measurement end of the secant tuning loop. Watches the `i_ref` value driven by the secant controller.
- After each change of `i_ref` (or an explicit `start`), waits a settling time, then averages 2^LOG2_AVG valid Q samples from the sensing path.
- Returns the average on `measured_q` with a one-cycle `ready` pulse, which the controller uses to advance its state.
- Also provides a watchdog for a stalled sample stream.

Parameters:
- WIDTH, 10: bus width of `i_ref`, samples and `measured_q`.
- SETTLE_CYC, 64: cycles waited after a trigger before sampling. Legal range is 1..1023.
- LOG2_AVG, 3: log2 of the number of samples averaged (N = 2^LOG2_AVG). Legal range is 0..6.
- TIMEOUT, 1023: maximum cycles allowed without an accepted sample while in ACCUM.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- i_ref  in  WIDTH  reference value currently applied by the controller.
- start  in  1  single-cycle request to re-measure without an `i_ref` change.
- sample  in  WIDTH  raw Q sample from the sensing path; unsigned.
- sample_valid  in  1  `sample` is accepted on any ACCUM-state edge where this is high.
- measured_q  out  WIDTH  averaged Q; holds its value between measurements.
- ready  out  1  one-cycle pulse when `measured_q` is updated.
- busy  out  1  high in SETTLE, ACCUM and DONE.
- timeout  out  1  one-cycle pulse when a measurement is abandoned.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; `measured_q`, `ready`, `busy`, `timeout` all 0.
  - Latched reference `ref_q`=0; accumulator and counters 0.
- Trigger: (`i_ref != ref_q`) OR `start`, sampled at a rising edge.
  - `ref_q` is updated to `i_ref` on every edge where a trigger occurs.
  - A change and `start` in the same cycle count as one trigger.
  - A nonzero `i_ref` after reset therefore causes a first measurement.
- FSM states IDLE, SETTLE, ACCUM, DONE:
  - IDLE -> SETTLE on trigger. The settle counter loads SETTLE_CYC-1.
  - SETTLE: counter decrements each cycle. At 0 -> ACCUM, with accumulator and sample count cleared and watchdog loaded to TIMEOUT.
  - SETTLE, on an `i_ref` change: counter reloads and state stays SETTLE. `start` is ignored here.
  - ACCUM: on `sample_valid`, acc += `sample` zero-extended, count++, watchdog reloads.
  - ACCUM, on the Nth accepted sample -> DONE.
  - ACCUM, on an `i_ref` change: accumulated data is discarded and the block goes to SETTLE (counter reload). This takes precedence over a same-cycle sample. `start` is ignored.
  - ACCUM, when no sample arrives: watchdog decrements. When it reaches 0 -> IDLE, `timeout`=1 for one cycle, no `ready`, `measured_q` unchanged.
  - DONE, one cycle: `measured_q` <= acc >> LOG2_AVG (truncating), `ready`=1.
  - DONE, next state: -> SETTLE if a trigger is present in this cycle, else -> IDLE.
- Width rules:
  - Accumulator is WIDTH+LOG2_AVG bits, unsigned, and can never overflow.
  - Sample counter is LOG2_AVG+1 bits.
  - Settle and watchdog counters are 10 bits.
- Latency: take the trigger edge as cycle 0 and hold `sample_valid` high continuously. Then `ready` is high during cycle SETTLE_CYC+N+1 and `measured_q` is valid in that same cycle.
- `ready` and `timeout` are never high together. Both are registered outputs.
- `busy` is a registered decode of the state (state != IDLE).

Decomposition:
- Package `q_measure_pkg`:
  - State enum (IDLE, SETTLE, ACCUM, DONE).
  - Helper localparams AVG_N = 1<<LOG2_AVG and ACC_W = WIDTH+LOG2_AVG.
  - Counter width constant CNT_W = 10.
- One sub-module, `q_meas_downcnt`: loadable 10-bit down-counter with `load`, `en` and a `zero` flag.
  - Instantiated twice: once for settle, once for the watchdog.

Test Plan:
- Reset with `i_ref`=0 held, then release: no `ready` for 2000 cycles; `busy`=0; `measured_q`=0.
- `i_ref` 0->200 with `sample`=300 and `sample_valid`=1 constantly (defaults): `ready` pulses exactly at cycle 73, with `measured_q`=300 and `busy` falling afterwards.
- Samples 1,2,3,4,5,6,7,9 gated by `sample_valid` toggling every other cycle: `measured_q`=37>>3=4, with one `ready` pulse.
- `i_ref` change at cycle 40 of SETTLE and again at the 3rd sample of ACCUM: settle restarts both times; `ready` comes only after a full new settle and 8 fresh samples; discarded samples do not affect the average.
- After settle, `sample_valid` held low: `timeout` pulses 1024 cycles after entry to ACCUM; no `ready`; `measured_q` keeps its previous value; state is IDLE.
- `rst` asserted mid-ACCUM: all outputs are 0 immediately (asynchronous). After release with an unchanged nonzero `i_ref`, a fresh measurement starts.
- `start` pulses in IDLE and while busy: a measurement runs only for the IDLE pulse; an `i_ref` change during DONE chains a new measurement.

Source files
------------

// File: rtl/q_measure_pkg.sv
// Shared types and sizing helpers for the Q measurement front end.
package q_measure_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned CNT_W        = 10;
  localparam int unsigned DEF_WIDTH    = 10;
  localparam int unsigned DEF_LOG2_AVG = 3;

  function automatic int unsigned avg_n(input int unsigned log2_avg);
    return 32'd1 << log2_avg;
  endfunction

  // Sum of 2^log2_avg unsigned width-bit samples never exceeds this many bits.
  function automatic int unsigned acc_w(input int unsigned width, input int unsigned log2_avg);
    return width + log2_avg;
  endfunction

  localparam int unsigned AVG_N = avg_n(DEF_LOG2_AVG);
  localparam int unsigned ACC_W = acc_w(DEF_WIDTH, DEF_LOG2_AVG);

endpackage

// File: rtl/q_meas_downcnt.sv
// Loadable down-counter that stops at zero; zero flag is registered alongside the count.
module q_meas_downcnt
  import q_measure_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (load) begin
      cnt_d = load_val;
    end else if (en && !zero) begin
      cnt_d = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      zero <= 1'b1;
    end else begin
      cnt  <= cnt_d;
      zero <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/q_measure_frontend.sv
// Settle-then-average Q measurement for the secant tuning loop, with a stalled-stream watchdog.
module q_measure_frontend
  import q_measure_pkg::*;
#(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned LOG2_AVG   = 3,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_ref,
  input  logic             start,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] measured_q,
  output logic             ready,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned N_AVG    = avg_n(LOG2_AVG);
  localparam int unsigned ACC_BITS = acc_w(WIDTH, LOG2_AVG);
  localparam int unsigned SCNT_W   = LOG2_AVG + 1;

  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  WD_LOAD     = CNT_W'(TIMEOUT);
  localparam logic [SCNT_W-1:0] LAST_SMP    = SCNT_W'(N_AVG - 1);

  state_e               state;
  state_e               state_d;
  logic [WIDTH-1:0]     ref_q;
  logic [ACC_BITS-1:0]  acc;
  logic [SCNT_W-1:0]    smp_cnt;

  logic ref_chg;
  logic trig;
  logic settle_load;
  logic settle_en;
  logic settle_zero;
  logic wd_load;
  logic wd_en;
  logic wd_zero;
  logic acc_clr;
  logic acc_add;
  logic ready_d;
  logic timeout_d;

  // A reference change and a start in the same cycle are a single trigger.
  assign ref_chg = (i_ref != ref_q);
  assign trig    = ref_chg | start;

  q_meas_downcnt u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (settle_load),
    .load_val (SETTLE_LOAD),
    .en       (settle_en),
    .zero     (settle_zero)
  );

  q_meas_downcnt u_wd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (WD_LOAD),
    .en       (wd_en),
    .zero     (wd_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and datapath strobes; a reference change always outranks a same-cycle sample.
  always_comb begin
    state_d     = state;
    settle_load = 1'b0;
    settle_en   = 1'b0;
    wd_load     = 1'b0;
    wd_en       = 1'b0;
    acc_clr     = 1'b0;
    acc_add     = 1'b0;
    ready_d     = 1'b0;
    timeout_d   = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          state_d     = SETTLE;
          settle_load = 1'b1;
        end
      end
      SETTLE: begin
        if (ref_chg) begin
          settle_load = 1'b1;
        end else if (settle_zero) begin
          state_d = ACCUM;
          acc_clr = 1'b1;
          wd_load = 1'b1;
        end else begin
          settle_en = 1'b1;
        end
      end
      ACCUM: begin
        if (ref_chg) begin
          state_d     = SETTLE;
          settle_load = 1'b1;
          acc_clr     = 1'b1;
        end else if (sample_valid) begin
          acc_add = 1'b1;
          wd_load = 1'b1;
          if (smp_cnt == LAST_SMP) begin
            state_d = DONE;
          end
        end else if (wd_zero) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          wd_en = 1'b1;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        if (trig) begin
          state_d     = SETTLE;
          settle_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q <= '0;
    end else if (trig) begin
      ref_q <= i_ref;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      smp_cnt <= '0;
    end else if (acc_clr) begin
      acc     <= '0;
      smp_cnt <= '0;
    end else if (acc_add) begin
      acc     <= acc + ACC_BITS'(sample);
      smp_cnt <= smp_cnt + SCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      measured_q <= '0;
      ready      <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (ready_d) begin
        measured_q <= WIDTH'(acc >> LOG2_AVG);
      end
      ready   <= ready_d;
      timeout <= timeout_d;
      busy    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_q_measure_frontend.sv
// Self-checking bench for q_measure_frontend: vector table, directed corner sequences, random trials.
module tb_q_measure_frontend;

  localparam int WIDTH      = 10;
  localparam int SETTLE     = 64;
  localparam int LOG2_AVG   = 3;
  localparam int TIMEOUT    = 1023;
  localparam int N          = 1 << LOG2_AVG;
  localparam int NVEC       = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] i_ref = '0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] sample = 10'd300;
  logic             sample_valid = 1'b1;
  logic [WIDTH-1:0] measured_q;
  logic             ready;
  logic             busy;
  logic             timeout;

  int n_chk  = 0;
  int n_fail = 0;

  bit               pat_v [256];
  logic [WIDTH-1:0] pat_s [256];
  int               pat_len;

  typedef struct {
    string                  name;
    logic [WIDTH-1:0]       iref;
    logic [7:0][WIDTH-1:0]  smp;
    bit                     alt;
    int                     exp_q;
    int                     exp_rdy;
  } vec_t;

  vec_t vecs [NVEC];

  q_measure_frontend #(
    .WIDTH      (WIDTH),
    .SETTLE_CYC (SETTLE),
    .LOG2_AVG   (LOG2_AVG),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_ref        (i_ref),
    .start        (start),
    .sample       (sample),
    .sample_valid (sample_valid),
    .measured_q   (measured_q),
    .ready        (ready),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Trigger with new_ref, drive garbage while settling, then pat_v/pat_s from ACCUM entry on.
  task automatic do_meas(input logic [WIDTH-1:0] new_ref, input bit with_start,
                         input int exp_rdy, input int exp_q, input string name);
    int rdy_at;
    int to_seen;
    int k;
    int jj;
    rdy_at  = -1;
    to_seen = 0;
    i_ref   = new_ref;
    start   = with_start;
    tick();
    start = 1'b0;
    k = 0;
    while (rdy_at < 0 && k < exp_rdy + 40) begin
      jj = k - SETTLE;
      if (k < SETTLE) begin
        sample       = WIDTH'($urandom);
        sample_valid = 1'($urandom);
      end else if (jj < pat_len) begin
        sample       = pat_s[jj];
        sample_valid = pat_v[jj];
      end else begin
        sample_valid = 1'b0;
      end
      tick();
      k++;
      if (timeout) to_seen = 1;
      if (ready) rdy_at = k;
    end
    chk({name, "_ready_cycle"}, rdy_at, exp_rdy);
    chk({name, "_measured_q"}, int'(measured_q), exp_q);
    chk({name, "_no_timeout"}, to_seen, 0);
    sample_valid = 1'b0;
    tick();
    chk({name, "_ready_single"}, int'(ready), 0);
    chk({name, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int n_rdy;
    int busy_seen;
    int first_rdy;
    int second_rdy;
    int q1;
    int q2;
    int to_at;

    // Vector table: trigger value, eight accepted samples, gapped valid, expected q and ready cycle.
    vecs[0].name = "step200";   vecs[0].iref = 10'd200;  vecs[0].alt = 1'b0;
    vecs[0].exp_q = 300;  vecs[0].exp_rdy = 73;
    vecs[1].name = "gapped";    vecs[1].iref = 10'd513;  vecs[1].alt = 1'b1;
    vecs[1].exp_q = 4;    vecs[1].exp_rdy = 80;
    vecs[2].name = "fullscale"; vecs[2].iref = 10'd1023; vecs[2].alt = 1'b0;
    vecs[2].exp_q = 1023; vecs[2].exp_rdy = 73;
    vecs[3].name = "trunc_lo";  vecs[3].iref = 10'd1;    vecs[3].alt = 1'b0;
    vecs[3].exp_q = 0;    vecs[3].exp_rdy = 73;
    vecs[4].name = "trunc_hi";  vecs[4].iref = 10'd77;   vecs[4].alt = 1'b1;
    vecs[4].exp_q = 1003; vecs[4].exp_rdy = 80;
    for (int i = 0; i < 8; i++) begin
      vecs[0].smp[i] = 10'd300;
      vecs[1].smp[i] = (i == 7) ? 10'd9 : WIDTH'(i + 1);
      vecs[2].smp[i] = 10'd1023;
      vecs[3].smp[i] = (i == 7) ? 10'd7 : 10'd0;
      vecs[4].smp[i] = WIDTH'(1000 + i);
    end

    // Reset held with i_ref = 0
    repeat (3) tick();
    chk("rst_ready", int'(ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_q", int'(measured_q), 0);
    rst = 1'b1;
    n_rdy = 0;
    busy_seen = 0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (ready) n_rdy++;
      if (busy) busy_seen = 1;
    end
    chk("idle_no_ready", n_rdy, 0);
    chk("idle_busy", busy_seen, 0);
    chk("idle_q", int'(measured_q), 0);

    for (int v = 0; v < NVEC; v++) begin
      if (vecs[v].alt) begin
        pat_len = 15;
        for (int j = 0; j < 15; j++) begin
          pat_v[j] = (j % 2 == 0);
          pat_s[j] = pat_v[j] ? vecs[v].smp[j / 2] : 10'd1023;
        end
      end else begin
        pat_len = 8;
        for (int j = 0; j < 8; j++) begin
          pat_v[j] = 1'b1;
          pat_s[j] = vecs[v].smp[j];
        end
      end
      do_meas(vecs[v].iref, 1'b0, vecs[v].exp_rdy, vecs[v].exp_q, vecs[v].name);
    end

    // Reference changes at settle cycle 40 and on the 3rd accepted sample
    i_ref = 10'd250; sample = 10'd999; sample_valid = 1'b1;
    tick();
    n_rdy = 0; first_rdy = -1;
    for (int k = 0; k < 250; k++) begin
      if (k == 40)  i_ref = 10'd251;
      if (k == 107) i_ref = 10'd252;
      sample = (k >= 172) ? 10'd50 : 10'd999;
      tick();
      if (ready) begin
        n_rdy++;
        if (first_rdy < 0) begin
          first_rdy = k + 1;
          q1 = int'(measured_q);
        end
      end
    end
    chk("retrig_ready_count", n_rdy, 1);
    chk("retrig_ready_cycle", first_rdy, 181);
    chk("retrig_q", q1, 50);

    // Stalled stream: watchdog abandons the measurement
    i_ref = 10'd600; sample_valid = 1'b0;
    tick();
    n_rdy = 0; to_at = -1;
    for (int k = 0; k < 1200 && to_at < 0; k++) begin
      tick();
      if (ready) n_rdy++;
      if (timeout) to_at = k + 1;
    end
    chk("wd_timeout_cycle", to_at, SETTLE + TIMEOUT + 1);
    chk("wd_no_ready", n_rdy, 0);
    chk("wd_q_held", int'(measured_q), 50);
    tick();
    chk("wd_timeout_single", int'(timeout), 0);
    chk("wd_idle", int'(busy), 0);

    // Asynchronous reset in the middle of ACCUM
    i_ref = 10'd321; sample = 10'd123; sample_valid = 1'b1;
    tick();
    repeat (66) tick();
    chk("mid_busy_before", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_q", int'(measured_q), 0);
    chk("async_ready", int'(ready), 0);
    chk("async_timeout", int'(timeout), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    first_rdy = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (ready && first_rdy < 0) begin
        first_rdy = k + 1;
        q1 = int'(measured_q);
      end
    end
    chk("post_rst_ready_cycle", first_rdy, 73);
    chk("post_rst_q", q1, 123);

    // start honoured only from IDLE
    sample = 10'd400; sample_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_rdy = 0; first_rdy = -1;
    for (int k = 0; k < 300; k++) begin
      start = (k == 10 || k == 66);
      tick();
      if (ready) begin
        n_rdy++;
        if (first_rdy < 0) begin
          first_rdy = k + 1;
          q1 = int'(measured_q);
        end
      end
    end
    start = 1'b0;
    chk("start_ready_count", n_rdy, 1);
    chk("start_ready_cycle", first_rdy, 73);
    chk("start_q", q1, 400);

    // Reference change during DONE chains a second measurement
    i_ref = 10'd444; sample = 10'd600; sample_valid = 1'b1;
    tick();
    n_rdy = 0; first_rdy = -1; second_rdy = -1; q1 = -1; q2 = -1;
    for (int k = 0; k < 200; k++) begin
      if (k == 72) i_ref = 10'd555;
      if (k == 74) sample = 10'd700;
      tick();
      if (ready) begin
        n_rdy++;
        if (first_rdy < 0) begin
          first_rdy = k + 1; q1 = int'(measured_q);
        end else begin
          second_rdy = k + 1; q2 = int'(measured_q);
        end
      end
    end
    chk("chain_ready_count", n_rdy, 2);
    chk("chain_first_cycle", first_rdy, 73);
    chk("chain_first_q", q1, 600);
    chk("chain_second_cycle", second_rdy, 146);
    chk("chain_second_q", q2, 700);

    // Random trials against an arithmetic model: mean of the first N valid samples after settling
    for (int t = 0; t < 20; t++) begin
      int cnt;
      int jn;
      int sum;
      int j;
      logic [WIDTH-1:0] nr;
      cnt = 0; sum = 0; j = 0; jn = 0;
      while (cnt < N) begin
        pat_v[j] = (j >= 200) ? 1'b1 : ($urandom_range(0, 2) != 0);
        pat_s[j] = WIDTH'($urandom);
        if (pat_v[j]) begin
          sum += int'(pat_s[j]);
          cnt++;
          jn = j;
        end
        j++;
      end
      pat_len = j;
      nr = WIDTH'($urandom);
      if (nr == i_ref) nr = nr ^ WIDTH'(1);
      do_meas(nr, 1'($urandom), SETTLE + jn + 2, sum / N, $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
